serial_rx_mmr: RTL
==================

Name: serial_rx_mmr

Overview:
- Memory-mapped UART receiver on the core operand bus; it deserialises the rxd pin, 8N1 framing, LSB first.
- Received bytes are buffered in a small FIFO.
- The core reads data and status registers through the shared rw/addr/data bus, using the same responder convention as the other mmr peripherals.
- It is the receive half paired with the txd path at the top level.

Parameters:
- BASE, 32'h00000200, word address of the DATA register; STATUS is at BASE+1.
- OVERSAMPLE_DIV, 27, clk cycles per 1/16 bit tick; 27 gives about 115200 baud at 50 MHz.
- DEPTH_LOG2, 3, log2 of FIFO depth; the default depth is 8 entries.

Ports:
- clk  input  1  core data-memory clock; all state changes on posedge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  when low, bus accesses are ignored (no drive, no pop); reception continues.
- rw  input  1  1 = core writing, 0 = core reading.
- addr  input  32  operand address.
- data  inout  32  operand data; driven only on an addressed read, otherwise high-Z.
- rxd  input  1  asynchronous serial input, idle high.
- rx_irq  output  1  high while the FIFO is non-empty.

Behaviour:
- Reset values: FIFO empty, rx_irq=0, overrun=0, ferr=0, FSM=IDLE, tick counter=0, synchroniser regs=1, data=Z.
- Input sync: rxd passes through a 2-flop synchroniser before any use.
- Tick generator: counts 0..OVERSAMPLE_DIV-1 and pulses tick for one clk on wrap. It runs freely, reset only by reset_n.
- FSM states:
  - IDLE: on a tick with rxd_s=0, go to START and set sample count=0.
  - START: on sample count 7 (mid-bit), if rxd_s=1 it is a glitch, return to IDLE with nothing recorded; else go to DATA with bit index=0 and sample count=0.
  - DATA: every 16 ticks sample rxd_s into shift[bitidx] (LSB first); after bit 7 go to STOP.
  - STOP: after 16 ticks sample rxd_s.
    - If 1: push the byte.
    - If 0: set ferr=1 and do not push; wait in BREAK until rxd_s=1, then go to IDLE.
    - After a valid stop bit, return to IDLE.
- FIFO: circular, with DEPTH_LOG2+1-bit read/write pointers; full when MSBs differ and the rest are equal.
  - Push when full: byte dropped, overrun=1, contents unchanged.
  - Push and pop in the same cycle when full: the pop proceeds, the push is dropped, overrun=1.
  - Push and pop in the same cycle when neither full nor empty: both proceed, count unchanged.
  - Push when empty with a simultaneous pop request: the pop is a no-op returning 0, the push proceeds.
- Bus read of DATA (enable=1, rw=0, addr==BASE):
  - data={24'b0, head byte} combinationally, or 32'b0 if empty.
  - On posedge the head is popped if non-empty.
  - Each clock edge with the read asserted pops once.
- Bus read of STATUS (addr==BASE+1):
  - data={16'b0, count[7:0], 4'b0, perr, ferr, overrun, ~empty}. perr is 0 unless the optional feature is compiled in.
  - Count width is zero-extended to 8 bits.
  - No side effects.
- Bus write to STATUS (rw=1): data bits [3:1] written as 1 clear the matching sticky flag (write-one-to-clear).
  - A flag set and cleared in the same cycle stays set.
- Bus write to DATA: ignored.
- Any other address: data=Z, no effect.
- rx_irq = ~empty, registered (lags the FIFO state by zero cycles; derived from pointer registers).
- Reset mid-frame: the FSM returns to IDLE immediately and the partial byte is discarded.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state is inserted after DATA and samples 1 bit.
  - If XOR(byte, parity bit) != 0, set sticky perr (STATUS bit 3, W1C) and do not push the byte.
- Not defined:
  - No PARITY state; perr is tied 0; frame is 8N1.

Test Plan:
- Reset, rxd idle high, read BASE+1 -> 32'h00000000; read BASE -> 32'h00000000; rx_irq=0.
- Send 8'hA5 then 8'h3C at nominal baud -> rx_irq=1; STATUS count=2, bit0=1; reads of BASE return 32'hA5 then 32'h3C; then STATUS=0 and rx_irq=0.
- Send 9 bytes 8'h01..8'h09 with no reads -> STATUS overrun=1, count=8; eight reads return 8'h01..8'h08; write 32'h2 to BASE+1 -> overrun=0.
- Hold rxd low for 20 bit times, then release -> ferr=1, count=0; write 32'h4 to BASE+1 clears ferr; next byte 8'h55 is received correctly.
- A 4-tick low glitch on idle rxd -> no byte, no flags; assert reset_n=0 mid-byte, release, send 8'h7E -> only 8'h7E is present.
- With SERIAL_RX_PARITY_EN: 8'h03 with parity bit 1 -> perr=1, count=0; 8'h03 with parity bit 0 -> read 32'h03.

Source files
------------

// File: rtl/serial_rx_mmr_if.sv
// serial_rx_mmr_if
//
// Purpose: bundles the core operand-bus control signals that select and
// qualify an access to the serial receiver's register window.
//
// Signals:
//   enable  1   access qualifier; when low the peripheral ignores the bus
//   rw      1   1 = core writing, 0 = core reading
//   addr    32  operand word address
//
// Modports:
//   master  the core side, drives enable/rw/addr
//   slave   the peripheral side, observes enable/rw/addr
//
// The shared 32-bit operand data bus is a resolved tri-state net with
// several drivers at the top level. It is therefore kept as a separate
// inout port on the peripheral rather than carried inside this bundle.

interface serial_rx_mmr_if;
    logic        enable;
    logic        rw;
    logic [31:0] addr;

    modport master (output enable, output rw, output addr);
    modport slave  (input enable, input rw, input addr);
endinterface

// File: rtl/serial_rx_mmr.sv
// serial_rx_mmr
//
// Purpose: memory-mapped UART receiver. It deserialises rxd (8N1, LSB first)
// using 16x oversampling and buffers received bytes in a small circular FIFO.
// The core reads the buffered data and status through the operand bus.
//
// Register map (word addresses):
//   BASE    DATA   read pops the head byte ({24'b0, byte}, or 0 when empty);
//                  writes are ignored
//   BASE+1  STATUS {16'b0, count[7:0], 4'b0, perr, ferr, overrun, ~empty};
//                  writing 1 to bits [3:1] clears the matching sticky flag
//
// Ports:
//   clk      core data-memory clock, all state changes on posedge
//   reset_n  asynchronous active-low reset
//   bus      serial_rx_mmr_if.slave: enable, rw, addr
//   data     32-bit operand data, driven only during an addressed read
//   rxd      asynchronous serial input, idle high
//   rx_irq   high while the FIFO holds at least one byte
//
// Optional feature: define SERIAL_RX_PARITY_EN for 8E1 framing. A parity bit
// is then sampled after the data bits; a bad parity sets the sticky perr flag
// and the byte is discarded. Without the macro perr reads as 0.

module serial_rx_mmr #(
    parameter logic [31:0] BASE           = 32'h0000_0200,
    parameter int          OVERSAMPLE_DIV = 27,
    parameter int          DEPTH_LOG2     = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    serial_rx_mmr_if.slave        bus,
    inout  wire  [31:0]           data,
    input  logic                  rxd,
    output logic                  rx_irq
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int TICK_W = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic              rxd_meta;
    logic              rxd_s;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    state_t            state_q, state_d;
    logic [3:0]        scnt_q, scnt_d;
    logic [2:0]        bitidx_q, bitidx_d;
    logic [7:0]        shift_q, shift_d;
    logic              push;
    logic              set_ferr;
    logic              set_perr;

    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [PTR_W-1:0]  count;
    logic [7:0]        mem [DEPTH];
    logic              empty, full, push_ok, pop;

    logic              rd_data_sel, rd_status_sel, wr_status_sel;
    logic [31:0]       rdata;
    logic              overrun, ferr, perr;
    logic              unused_data;

`ifdef SERIAL_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
`endif

    // Two-flop synchroniser; both stages reset to the idle line level so a
    // reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Free-running 1/16-bit tick; it is never resynchronised to the frame,
    // so the start-edge detection carries up to one tick of uncertainty.
    assign tick = (tick_cnt == TICK_W'(OVERSAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Receiver state register and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            scnt_q   <= '0;
            bitidx_q <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            bitidx_q <= bitidx_d;
            shift_q  <= shift_d;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad_q <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
        end
    end
`endif

    // Frame sequencing. The start bit is confirmed 8 ticks after the falling
    // edge (mid-bit); every later bit is then sampled 16 ticks apart, which
    // keeps all samples near bit centres.
    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bitidx_d = bitidx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        set_ferr = 1'b0;
        set_perr = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tick && !rxd_s) begin
                    state_d = S_START;
                    scnt_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (scnt_q == 4'd7) begin
                        if (rxd_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d  = S_DATA;
                            bitidx_d = '0;
                            scnt_d   = '0;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (scnt_q == 4'd15) begin
                        shift_d[bitidx_q] = rxd_s;
                        scnt_d            = '0;
                        if (bitidx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bitidx_d = bitidx_q + 3'd1;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (scnt_q == 4'd15) begin
                        scnt_d    = '0;
                        state_d   = S_STOP;
                        par_bad_d = (^shift_q) ^ rxd_s;
                        set_perr  = (^shift_q) ^ rxd_s;
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (scnt_q == 4'd15) begin
                        scnt_d = '0;
                        if (rxd_s) begin
                            state_d = S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
                            push    = !par_bad_q;
`else
                            push    = 1'b1;
`endif
                        end else begin
                            set_ferr = 1'b1;
                            state_d  = S_BREAK;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
            end
            S_BREAK: begin
                // A framing error usually means a held-low line; wait for
                // the line to return high before hunting for a new start.
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus decode for the two registers.
    assign rd_data_sel   = bus.enable && !bus.rw && (bus.addr == BASE);
    assign rd_status_sel = bus.enable && !bus.rw && (bus.addr == BASE + 32'd1);
    assign wr_status_sel = bus.enable &&  bus.rw && (bus.addr == BASE + 32'd1);

    // FIFO pointers carry one extra wrap bit so full and empty are distinct.
    // A push into a full FIFO is dropped even when a pop happens in the same
    // cycle; a pop of an empty FIFO is a no-op.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                     (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
    assign push_ok = push && !full;
    assign pop     = rd_data_sel && !empty;
    assign count   = wptr_q - rptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= shift_q;
        end
    end

    // Sticky flags: a new event in the same cycle as a clear keeps the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            overrun <= (push && full) | (overrun & ~(wr_status_sel & data[1]));
            ferr    <= set_ferr | (ferr & ~(wr_status_sel & data[2]));
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr <= 1'b0;
        end else begin
            perr <= set_perr | (perr & ~(wr_status_sel & data[3]));
        end
    end
`else
    assign perr = set_perr;
`endif

    // Read mux; the bus is only driven while one of our registers is read.
    always_comb begin
        rdata = '0;
        if (rd_data_sel) begin
            rdata = empty ? 32'h0 : {24'b0, mem[rptr_q[DEPTH_LOG2-1:0]]};
        end else if (rd_status_sel) begin
            rdata = {16'b0, 8'(count), 4'b0, perr, ferr, overrun, ~empty};
        end
    end

    assign data   = (rd_data_sel || rd_status_sel) ? rdata : 'z;
    assign rx_irq = ~empty;

    // Only bits [3:1] of the write data matter; fold the rest away.
    assign unused_data = ^data;

endmodule
